// File: rtl/ofifo_col.sv
// rtl/ofifo_col.sv - per-lane output FIFO that re-aligns skewed psum columns into full rows
// Each lane is an independent circular buffer; a row pops only when every lane holds data.
module ofifo_col #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [col*psum_bw-1:0]   in,
    input  logic [col-1:0]           wr,
    input  logic                     rd,
    output logic [col*psum_bw-1:0]   out,
    output logic                     o_valid,
    output logic                     o_full,
    output logic                     o_ready,
    output logic                     o_overflow
);

    localparam int aw = $clog2(depth);

    logic [aw:0]        wptr_q [col];
    logic [aw:0]        wptr_d [col];
    logic [aw:0]        rptr_q [col];
    logic [aw:0]        rptr_d [col];
    logic               overflow_q;
    logic               overflow_d;
    logic [psum_bw-1:0] mem_q  [col][depth];

    logic [col-1:0]     empty;
    logic [col-1:0]     full;
    logic [col-1:0]     accept;
    logic [col-1:0]     we;
    logic               pop;

    always_comb begin
        for (int i = 0; i < col; i++) begin
            empty[i] = (wptr_q[i] == rptr_q[i]);
            full[i]  = (wptr_q[i][aw] != rptr_q[i][aw]) &&
                       (wptr_q[i][aw-1:0] == rptr_q[i][aw-1:0]);
        end
    end

    assign o_valid    = &(~empty);
    assign o_full     = |full;
    assign o_ready    = ~o_full;
    assign o_overflow = overflow_q;
    assign pop        = rd & o_valid;

    // A full lane still accepts when the same edge pops a row, freeing its head slot.
    always_comb begin
        overflow_d = overflow_q;
        for (int i = 0; i < col; i++) begin
            accept[i] = ~full[i] | pop;
            we[i]     = wr[i] & accept[i];
            wptr_d[i] = wptr_q[i] + {{aw{1'b0}}, we[i]};
            rptr_d[i] = rptr_q[i] + {{aw{1'b0}}, pop};
        end
        if ((wr & ~accept) != '0)
            overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < col; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
            end
            overflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < col; i++) begin
                wptr_q[i] <= wptr_d[i];
                rptr_q[i] <= rptr_d[i];
            end
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < col; i++) begin
            if (we[i])
                mem_q[i][wptr_q[i][aw-1:0]] <= in[i*psum_bw +: psum_bw];
        end
    end

    // Empty lanes read as zero so uninitialised storage never leaks out after reset.
    always_comb begin
        out = '0;
        for (int i = 0; i < col; i++) begin
            if (!empty[i])
                out[i*psum_bw +: psum_bw] = mem_q[i][rptr_q[i][aw-1:0]];
        end
    end

endmodule

// File: tb/tb_ofifo_col.sv
// tb/tb_ofifo_col.sv - self-checking bench for ofifo_col
module tb_ofifo_col;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [127:0] din = '0;
    logic [7:0]   wr = '0;
    logic         rd = 1'b0;
    logic [127:0] out;
    logic         o_valid, o_full, o_ready, o_overflow;

    int tests = 0;
    int fails = 0;

    ofifo_col #(.col(8), .psum_bw(16), .depth(64)) dut (
        .clk(clk), .reset(reset), .in(din), .wr(wr), .rd(rd), .out(out),
        .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]   wr;
        logic         rd;
        logic         exp_valid;
        logic         exp_full;
        logic         exp_ovf;
        logic [127:0] exp_out;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic [7:0] w, input logic [127:0] d, input logic r);
        wr  = w;
        din = d;
        rd  = r;
        @(posedge clk);
        #1;
        wr = '0;
        rd = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        wr = '0;
        rd = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [127:0] row(input logic [15:0] v);
        return {8{v}};
    endfunction

    function automatic logic [127:0] lane_row(input logic [15:0] base);
        logic [127:0] r;
        for (int j = 0; j < 8; j++) r[j*16 +: 16] = base ^ 16'(j << 12);
        return r;
    endfunction

    logic [127:0] skew_data;

    initial begin
        for (int j = 0; j < 8; j++) skew_data[j*16 +: 16] = 16'h0100 + 16'(j);
        for (int i = 0; i < 8; i++) begin
            vecs[i].wr        = 8'(1 << i);
            vecs[i].rd        = 1'b0;
            vecs[i].exp_valid = (i == 7);
            vecs[i].exp_full  = 1'b0;
            vecs[i].exp_ovf   = 1'b0;
            vecs[i].exp_out   = '0;
            for (int j = 0; j <= i; j++) vecs[i].exp_out[j*16 +: 16] = 16'h0100 + 16'(j);
        end
        vecs[8] = '{wr: 8'h00, rd: 1'b1, exp_valid: 1'b0, exp_full: 1'b0, exp_ovf: 1'b0, exp_out: '0};

        do_reset();
        #1;
        chk("reset_out", out, '0);
        chk("reset_valid", {127'd0, o_valid}, 128'd0);
        chk("reset_full", {127'd0, o_full}, 128'd0);
        chk("reset_ready", {127'd0, o_ready}, 128'd1);
        chk("reset_ovf", {127'd0, o_overflow}, 128'd0);

        for (int i = 0; i < 9; i++) begin
            cyc(vecs[i].wr, skew_data, vecs[i].rd);
            chk($sformatf("skew%0d_valid", i), {127'd0, o_valid}, {127'd0, vecs[i].exp_valid});
            chk($sformatf("skew%0d_full", i), {127'd0, o_full}, {127'd0, vecs[i].exp_full});
            chk($sformatf("skew%0d_ovf", i), {127'd0, o_overflow}, {127'd0, vecs[i].exp_ovf});
            chk($sformatf("skew%0d_out", i), out, vecs[i].exp_out);
        end

        // Fill to full, then overflow lane 3.
        for (int k = 0; k < 64; k++) begin
            cyc(8'hFF, row(16'(k)), 1'b0);
            if (k == 62) chk("fill63_full", {127'd0, o_full}, 128'd0);
        end
        chk("fill64_full", {127'd0, o_full}, 128'd1);
        chk("fill64_ready", {127'd0, o_ready}, 128'd0);
        chk("fill64_ovf", {127'd0, o_overflow}, 128'd0);
        cyc(8'h08, row(16'hDEAD), 1'b0);
        chk("ovf_set", {127'd0, o_overflow}, 128'd1);
        for (int k = 0; k < 64; k++) begin
            chk($sformatf("drain%0d", k), out, row(16'(k)));
            cyc(8'h00, '0, 1'b1);
        end
        chk("drain_valid", {127'd0, o_valid}, 128'd0);
        chk("drain_full", {127'd0, o_full}, 128'd0);
        chk("ovf_sticky", {127'd0, o_overflow}, 128'd1);
        cyc(8'h00, '0, 1'b1);
        chk("rd_empty_ignored", {127'd0, o_valid}, 128'd0);

        // Write-through-full.
        do_reset();
        for (int k = 0; k < 64; k++) cyc(8'hFF, row(16'(k)), 1'b0);
        cyc(8'hFF, row(16'hBEEF), 1'b1);
        chk("wtf_ovf", {127'd0, o_overflow}, 128'd0);
        chk("wtf_full", {127'd0, o_full}, 128'd1);
        for (int j = 1; j <= 64; j++) begin
            chk($sformatf("wtf_pop%0d", j), out, (j < 64) ? row(16'(j)) : row(16'hBEEF));
            cyc(8'h00, '0, 1'b1);
        end
        chk("wtf_empty", {127'd0, o_valid}, 128'd0);

        // Wrap with half-row skew.
        do_reset();
        for (int v = 0; v < 200; v++) begin
            cyc(8'h0F, lane_row(16'(v + 1)), 1'b0);
            chk($sformatf("wrap%0d_half", v), {127'd0, o_valid}, 128'd0);
            cyc(8'hF0, lane_row(16'(v + 1)), 1'b0);
            chk($sformatf("wrap%0d_valid", v), {127'd0, o_valid}, 128'd1);
            chk($sformatf("wrap%0d_row", v), out, lane_row(16'(v + 1)));
            cyc(8'h00, '0, 1'b1);
            chk($sformatf("wrap%0d_empty", v), {127'd0, o_valid}, 128'd0);
        end

        // Asynchronous reset mid-stream.
        for (int k = 0; k < 10; k++) cyc(8'hFF, row(16'h0A00 + 16'(k)), 1'b0);
        chk("mid_valid_before", {127'd0, o_valid}, 128'd1);
        rd = 1'b1;
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("mid_valid_async", {127'd0, o_valid}, 128'd0);
        chk("mid_out_async", out, '0);
        rd = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cyc(8'hFF, row(16'h1234), 1'b0);
        cyc(8'hFF, row(16'h5678), 1'b0);
        chk("post_first", out, row(16'h1234));
        cyc(8'h00, '0, 1'b1);
        chk("post_second", out, row(16'h5678));
        cyc(8'h00, '0, 1'b1);
        chk("post_empty", {127'd0, o_valid}, 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
